unified_cache_mem_responder: RTL and testbench

//  Synthesizable single-port backing-memory responder below unified_cache's to_mem/from_mem ports.
//  - Accepts one cache->memory packet at a time and models access latency.
//  - Commits byte-masked writes to a block array.
//  - Returns read packets with a valid/ack handshake.
//  - Replaces ad-hoc behavioural memory in cache benches and serves as the FPGA memory stub.

---
 rtl/unified_cache_mem_responder_pkg.sv | 44 ++++
 rtl/unified_cache_mem_responder_block_ram.sv | 27 ++
 rtl/unified_cache_mem_responder.sv | 111 +++++++++++
 tb/tb_unified_cache_mem_responder.sv | 137 +++++++++++++
 4 files changed

// File: rtl/unified_cache_mem_responder_pkg.sv
// Shared packet layout, FSM states and return-packet builder for the unified_cache memory responder.
package unified_cache_mem_responder_pkg;

    localparam int UNIFIED_CACHE_BLOCK_OFFSET_LEN_IN_BITS = 6;
    localparam int UNIFIED_CACHE_ADDR_LEN_IN_BITS         = 32;
    localparam int UNIFIED_CACHE_BLOCK_SIZE_IN_BITS       = 64;
    localparam int UNIFIED_CACHE_BYTE_MASK_LEN            = UNIFIED_CACHE_BLOCK_SIZE_IN_BITS / 8;
    localparam int UNIFIED_CACHE_PORT_NUM_LEN             = 2;
    localparam int UNIFIED_CACHE_TYPE_LEN                 = 2;

    typedef struct packed {
        logic [UNIFIED_CACHE_ADDR_LEN_IN_BITS-1:0]   addr;
        logic [UNIFIED_CACHE_BLOCK_SIZE_IN_BITS-1:0] data;
        logic [UNIFIED_CACHE_BYTE_MASK_LEN-1:0]      byte_mask;
        logic [UNIFIED_CACHE_PORT_NUM_LEN-1:0]       port_num;
        logic [UNIFIED_CACHE_TYPE_LEN-1:0]           pkt_type;
        logic                                        cacheable;
        logic                                        is_write;
        logic                                        valid;
    } cache_packet_t;

    localparam int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = $bits(cache_packet_t);

    typedef enum logic [1:0] {
        MEM_RESP_STATE_IDLE,
        MEM_RESP_STATE_DELAY,
        MEM_RESP_STATE_WRITE,
        MEM_RESP_STATE_READ_RETURN
    } mem_resp_state_e;

    // Read return keeps the request's routing fields and swaps in the block data.
    function automatic cache_packet_t make_return_packet(
        input cache_packet_t                               req,
        input logic [UNIFIED_CACHE_BLOCK_SIZE_IN_BITS-1:0] data
    );
        cache_packet_t ret;
        ret          = req;
        ret.data     = data;
        ret.is_write = 1'b0;
        ret.valid    = 1'b1;
        return ret;
    endfunction

endpackage

// File: rtl/unified_cache_mem_responder_block_ram.sv
// Block array with one registered read port and one byte-masked write port; contents survive reset.
module unified_cache_mem_responder_block_ram #(
    parameter int DEPTH  = 65536,
    parameter int IDX_W  = 16,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [DATA_W/8-1:0] wr_mask,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [DATA_W-1:0]   rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wr_mask[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
        rd_data <= mem[rd_idx];
    end

endmodule

// File: rtl/unified_cache_mem_responder.sv
// Single-outstanding backing-memory responder for unified_cache with modelled access latency.
// Optional MEM_RESPONDER_RANDOM_DELAY_EN adds 0..15 LFSR-driven extra delay cycles per request.
module unified_cache_mem_responder
    import unified_cache_mem_responder_pkg::*;
#(
    parameter int MEM_SIZE_IN_BLOCKS = 65536,
    parameter int MEM_DELAY          = 10
) (
    input  logic                                          clk_in,
    input  logic                                          reset_in,
    input  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] cache_packet_in,
    output logic                                          cache_packet_ack_out,
    output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] mem_packet_out,
    input  logic                                          mem_packet_ack_in
);

    localparam int IDX_W = $clog2(MEM_SIZE_IN_BLOCKS);
`ifdef MEM_RESPONDER_RANDOM_DELAY_EN
    localparam int CNT_W = $clog2(MEM_DELAY + 16);
`else
    localparam int CNT_W = $clog2(MEM_DELAY + 1);
`endif

    mem_resp_state_e state, state_next;
    cache_packet_t   pkt_in, req, out_q;
    logic [CNT_W-1:0] cnt, delay_len;
    logic            accept, cnt_done;
    logic [IDX_W-1:0] idx;
    logic [UNIFIED_CACHE_BLOCK_SIZE_IN_BITS-1:0] rd_data;

    assign pkt_in         = cache_packet_t'(cache_packet_in);
    assign mem_packet_out = out_q;
    assign idx            = req.addr[UNIFIED_CACHE_BLOCK_OFFSET_LEN_IN_BITS +: IDX_W];
    assign cnt_done       = (cnt == delay_len - CNT_W'(1));

`ifdef MEM_RESPONDER_RANDOM_DELAY_EN
    logic [15:0] lfsr, lfsr_next;
    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // Per-request delay is fixed at accept so it cannot shift mid-count.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            lfsr      <= 16'hACE1;
            delay_len <= CNT_W'(MEM_DELAY);
        end else if (accept) begin
            lfsr      <= lfsr_next;
            delay_len <= CNT_W'(MEM_DELAY) + CNT_W'(lfsr_next[3:0]);
        end
    end
`else
    assign delay_len = CNT_W'(MEM_DELAY);
`endif

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            MEM_RESP_STATE_IDLE: begin
                accept = pkt_in.valid && !cache_packet_ack_out;
                if (accept) state_next = MEM_RESP_STATE_DELAY;
            end
            MEM_RESP_STATE_DELAY: begin
                if (cnt_done) state_next = req.is_write ? MEM_RESP_STATE_WRITE : MEM_RESP_STATE_READ_RETURN;
            end
            MEM_RESP_STATE_WRITE: state_next = MEM_RESP_STATE_IDLE;
            MEM_RESP_STATE_READ_RETURN: begin
                if (out_q.valid && mem_packet_ack_in) state_next = MEM_RESP_STATE_IDLE;
            end
            default: state_next = MEM_RESP_STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state                <= MEM_RESP_STATE_IDLE;
            cache_packet_ack_out <= 1'b0;
            out_q                <= '0;
            cnt                  <= '0;
            req                  <= '0;
        end else begin
            state                <= state_next;
            cache_packet_ack_out <= accept;
            if (accept) begin
                req <= pkt_in;
                cnt <= '0;
            end else if (state == MEM_RESP_STATE_DELAY) begin
                cnt <= cnt + CNT_W'(1);
            end
            // First READ_RETURN cycle loads the packet; ack is only honoured once it is visible.
            if (state == MEM_RESP_STATE_READ_RETURN) begin
                if (!out_q.valid)          out_q <= make_return_packet(req, rd_data);
                else if (mem_packet_ack_in) out_q <= '0;
            end
        end
    end

    unified_cache_mem_responder_block_ram #(
        .DEPTH  (MEM_SIZE_IN_BLOCKS),
        .IDX_W  (IDX_W),
        .DATA_W (UNIFIED_CACHE_BLOCK_SIZE_IN_BITS)
    ) u_ram (
        .clk     (clk_in),
        .wr_en   (state == MEM_RESP_STATE_WRITE && req.valid),
        .wr_idx  (idx),
        .wr_mask (req.byte_mask),
        .wr_data (req.data),
        .rd_idx  (idx),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_unified_cache_mem_responder.sv
// Directed bench for unified_cache_mem_responder in its default (fixed-delay) build.
module tb_unified_cache_mem_responder;
    import unified_cache_mem_responder_pkg::*;

    localparam int W = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;

    logic         clk = 1'b0;
    logic         reset_in;
    logic [W-1:0] cache_packet_in;
    logic         cache_packet_ack_out;
    logic [W-1:0] mem_packet_out;
    logic         mem_packet_ack_in;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    unified_cache_mem_responder #(.MEM_SIZE_IN_BLOCKS(65536), .MEM_DELAY(10)) dut (
        .clk_in               (clk),
        .reset_in             (reset_in),
        .cache_packet_in      (cache_packet_in),
        .cache_packet_ack_out (cache_packet_ack_out),
        .mem_packet_out       (mem_packet_out),
        .mem_packet_ack_in    (mem_packet_ack_in)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic cache_packet_t mk(input logic [31:0] addr, input logic [63:0] data,
                                         input logic [7:0] mask, input logic [1:0] port,
                                         input logic [1:0] typ, input logic cach, input logic wr);
        cache_packet_t p;
        p.addr = addr; p.data = data; p.byte_mask = mask; p.port_num = port;
        p.pkt_type = typ; p.cacheable = cach; p.is_write = wr; p.valid = 1'b1;
        return p;
    endfunction

    // Present a request; returns #1 after accept edge E with the ack pulse checked.
    task automatic send(input string tag, input cache_packet_t p);
        @(negedge clk);
        cache_packet_in = p;
        @(posedge clk); #1;
        check({tag, "_ack_hi"}, 128'(cache_packet_ack_out), 128'd1);
        cache_packet_in = '0;
    endtask

    task automatic do_write(input string tag, input cache_packet_t p);
        send(tag, p);
        repeat (11) @(posedge clk);
        #1;
    endtask

    task automatic do_read(input string tag, input cache_packet_t p, input logic [63:0] exp_data,
                           input int hold);
        cache_packet_t exp;
        int lat;
        exp = p; exp.data = exp_data; exp.is_write = 1'b0; exp.valid = 1'b1;
        send(tag, p);
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (mem_packet_out[0]) lat = k;
        end
        check({tag, "_latency"}, 128'(lat), 128'd11);
        check({tag, "_pkt"}, 128'(mem_packet_out), 128'(exp));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, 128'(mem_packet_out), 128'(exp));
        end
        mem_packet_ack_in = 1'b1;
        @(posedge clk); #1;
        mem_packet_ack_in = 1'b0;
        check({tag, "_clr"}, 128'(mem_packet_out), 128'd0);
        @(posedge clk); #1;
        check({tag, "_idle_out"}, 128'(mem_packet_out), 128'd0);
    endtask

    initial begin
        reset_in = 1'b1; cache_packet_in = '0; mem_packet_ack_in = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check("rst_ack", 128'(cache_packet_ack_out), 128'd0);
                check("rst_out", 128'(mem_packet_out), 128'd0);
            end
        end
        reset_in = 1'b0;

        // Full write to block 1 with commit-edge timing and no return packet.
        send("wr1", mk(32'h40, 64'hDEADBEEF_DEADBEEF, 8'hFF, 2'd0, 2'd0, 1'b1, 1'b1));
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            check("wr1_ack_lo", 128'(cache_packet_ack_out), 128'd0);
            check("wr1_out_zero", 128'(mem_packet_out), 128'd0);
            if (k == 10) check("wr1_before_commit", 128'(dut.u_ram.mem[1] === 64'hDEADBEEF_DEADBEEF), 128'd0);
            if (k == 11) check("wr1_commit", 128'(dut.u_ram.mem[1]), 128'(64'hDEADBEEF_DEADBEEF));
        end

        do_read("rd1", mk(32'h40, 64'h0, 8'hFF, 2'd1, 2'd2, 1'b1, 1'b0), 64'hDEADBEEF_DEADBEEF, 5);

        do_write("pwr", mk(32'h40, 64'h11111111_11111111, 8'h0F, 2'd0, 2'd0, 1'b1, 1'b1));
        do_read("rd2", mk(32'h48, 64'h0, 8'hF0, 2'd3, 2'd1, 1'b0, 1'b0), 64'hDEADBEEF_11111111, 1);

        // Index MEM_SIZE_IN_BLOCKS aliases block 0.
        do_write("wrap_wr", mk(32'h0040_0000, 64'h01234567_89ABCDEF, 8'hFF, 2'd0, 2'd0, 1'b1, 1'b1));
        do_read("wrap_rd", mk(32'h0, 64'h0, 8'hFF, 2'd2, 2'd0, 1'b1, 1'b0), 64'h01234567_89ABCDEF, 0);

        // Reset during DELAY abandons the write.
        do_write("pre_wr", mk(32'h80, 64'hA5A5A5A5_5A5A5A5A, 8'hFF, 2'd0, 2'd0, 1'b1, 1'b1));
        send("abort_wr", mk(32'h80, 64'hFFFFFFFF_00000000, 8'hFF, 2'd0, 2'd0, 1'b1, 1'b1));
        repeat (4) @(posedge clk);
        @(negedge clk); reset_in = 1'b1;
        @(negedge clk); @(negedge clk); reset_in = 1'b0;
        check("abort_ack", 128'(cache_packet_ack_out), 128'd0);
        repeat (15) @(posedge clk);
        #1;
        check("abort_ack_after", 128'(cache_packet_ack_out), 128'd0);
        check("abort_out_after", 128'(mem_packet_out), 128'd0);
        check("abort_mem", 128'(dut.u_ram.mem[2]), 128'(64'hA5A5A5A5_5A5A5A5A));
        do_read("abort_rd", mk(32'h80, 64'h0, 8'hFF, 2'd1, 2'd3, 1'b0, 1'b0), 64'hA5A5A5A5_5A5A5A5A, 0);

        // Back-to-back reads: each exactly MEM_DELAY+1.
        for (int i = 0; i < 4; i++)
            do_read("b2b_rd", mk(32'h40, 64'h0, 8'hFF, 2'(i), 2'd0, 1'b1, 1'b0), 64'hDEADBEEF_11111111, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
